mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer_if.sv | 30 +++
 rtl/mul_sequencer.sv | 105 ++++++++++
 tb/tb_mul_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Multiply sequencer bus: EX-stage request, shared-ALU hookup, and stall/result back to the pipeline.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             ex_valid;
  logic [10:0]      ex_opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic [WIDTH-1:0] alu_y;
  logic             alu_sel;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] product;

  // Pipeline/ALU side.
  modport master (
    output ex_valid, ex_opcode, op_a, op_b, flush, alu_y,
    input  alu_sel, alu_ctl, alu_a, alu_b, stall, done, product
  );

  // Sequencer side.
  modport slave (
    input  ex_valid, ex_opcode, op_a, op_b, flush, alu_y,
    output alu_sel, alu_ctl, alu_a, alu_b, stall, done, product
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiply sequencer that borrows the EX-stage ALU and stalls the pipeline until done.
// Optional MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module mul_sequencer #(
  parameter int unsigned WIDTH      = 64,
  parameter logic [10:0] MUL_OPCODE = 11'b10011011000
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_sequencer_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [3:0]  ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] prod, prod_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      prod   <= prod_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state and ALU/pipeline control; nothing here depends on alu_y except register inputs.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    prod_nxt    = prod;
    cnt_nxt     = cnt;
    bus.alu_sel = 1'b0;
    bus.alu_ctl = 4'b0000;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.stall   = 1'b0;
    bus.done    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.ex_valid && (bus.ex_opcode == MUL_OPCODE) && !bus.flush) begin
          bus.stall  = 1'b1;
          acc_nxt    = '0;
          mcand_nxt  = bus.op_a;
          mplier_nxt = bus.op_b;
          cnt_nxt    = '0;
          state_nxt  = RUN;
`ifdef MUL_EARLY_EXIT_EN
          if (bus.op_b == '0) begin
            prod_nxt  = '0;
            state_nxt = DONE;
          end
`endif
        end
      end
      RUN: begin
        bus.alu_sel = 1'b1;
        bus.alu_ctl = ALU_ADD;
        bus.alu_a   = acc;
        bus.alu_b   = mplier[0] ? mcand : '0;
        bus.stall   = 1'b1;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt    = bus.alu_y;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
          if ((cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0)) begin
`else
          if (cnt == CNT_W'(WIDTH - 1)) begin
`endif
            prod_nxt  = bus.alu_y;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.product = prod;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer; the bench models the shared ALU's add path.
module tb_mul_sequencer;
  localparam int unsigned WIDTH = 64;
  localparam logic [10:0] MUL_OP = 11'b10011011000;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_sequencer #(.WIDTH(WIDTH), .MUL_OPCODE(MUL_OP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared EX-stage ALU: only the add code matters here.
  assign bus.alu_y = (bus.alu_ctl == 4'b0010) ? (bus.alu_a + bus.alu_b) : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycles from start to done for a given multiplier.
  function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int p;
    if (b == 64'd0) return 1;
    p = 0;
    for (int i = 0; i < 64; i++) if (b[i]) p = i;
    return p + 2;
`else
    return 65;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic start_mul(input logic [63:0] a, input logic [63:0] b);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = MUL_OP;
    bus.op_a      = a;
    bus.op_b      = b;
  endtask

  // Issue a MUL (caller sits just after a rising edge) and follow it to the done pulse.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                         output int lat, output int stall_cnt, output int bad_ctl,
                         output logic [63:0] first_b);
    start_mul(a, b);
    lat = -1; stall_cnt = 0; bad_ctl = 0; first_b = '1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        if (bus.stall || bus.alu_sel) bad_ctl++;
        break;
      end
      if (bus.stall) stall_cnt++;
      if (c == 1) first_b = bus.alu_b;
      if (c > 0 && (bus.alu_sel !== 1'b1 || bus.alu_ctl !== 4'b0010)) bad_ctl++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic mul_and_check(input string name, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp);
    int lat, sc, bc;
    logic [63:0] fb;
    run_mul(a, b, lat, sc, bc, fb);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({name, "_product"}, bus.product, exp);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_opcode = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_alu_sel", 64'(bus.alu_sel), 64'd0);
    chk("reset_alu_ctl", 64'(bus.alu_ctl), 64'd0);
    chk("reset_alu_ab", bus.alu_a | bus.alu_b, 64'd0);
    chk("reset_product", bus.product, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, sc, bc;
    logic [63:0] fb;
    run_mul(64'd3, 64'd5, lat, sc, bc, fb);
    chk("basic_latency", 64'(lat), 64'(exp_lat(64'd5)));
    chk("basic_stall_cycles", 64'(sc), 64'(exp_lat(64'd5)));
    chk("basic_alu_ctl_run", 64'(bc), 64'd0);
    chk("basic_first_alu_b", fb, 64'd3);
    chk("basic_product", bus.product, 64'd15);
    @(negedge clk);
    chk("basic_done_single", 64'(bus.done), 64'd0);
  endtask

  task automatic test_flush;
    int dcnt;
    @(posedge clk); #1;
    start_mul(64'd7, 64'h8000_0000_0000_0003);
    repeat (20) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("flush_stall_in_cycle", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_stall_next", 64'(bus.stall), 64'd0);
    chk("flush_alu_sel", 64'(bus.alu_sel), 64'd0);
    chk("flush_product_kept", bus.product, 64'd15);
    dcnt = 0;
    repeat (5) begin @(negedge clk); if (bus.done) dcnt++; end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    start_mul(64'd11, 64'h8000_0000_0000_000D);
    repeat (11) begin @(posedge clk); #1; end
    chk("midrun_stall_before", 64'(bus.stall), 64'd1);
    rst_n = 1'b0;
    bus.ex_valid = 1'b0;
    #1;
    chk("midrun_stall", 64'(bus.stall), 64'd0);
    chk("midrun_alu_sel", 64'(bus.alu_sel), 64'd0);
    chk("midrun_alu_ctl", 64'(bus.alu_ctl), 64'd0);
    chk("midrun_done", 64'(bus.done), 64'd0);
    chk("midrun_product", bus.product, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mul_and_check("after_reset", 64'd2, 64'd3, 64'd6);
  endtask

  task automatic test_overflow;
    mul_and_check("all_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    mul_and_check("wrap_2p64", 64'h1_0000_0000, 64'h1_0000_0000, 64'd0);
  endtask

  task automatic test_back_to_back;
    mul_and_check("b2b_first", 64'd4, 64'd5, 64'd20);
    mul_and_check("b2b_second", 64'd6, 64'd7, 64'd42);
  endtask

  task automatic test_early_exit;
    mul_and_check("ee_7x2", 64'd7, 64'd2, 64'd14);
    mul_and_check("ee_9x0", 64'd9, 64'd0, 64'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    bus.flush = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_reset_mid_run();
    test_overflow();
    test_back_to_back();
    test_early_exit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
